// File: rtl/pc16_unit.sv
// pc16_unit: 16-bit program counter stage for the m6502 model.
// Supports increment, independent low/high byte loads from the data bus,
// and relative branches. A branch that crosses a page takes one extra
// cycle, in FIX state, to apply the carry or borrow to the high byte.
module pc16_unit #(
  parameter logic [15:0] RST_PC = 16'hFFFC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       ldl,
  input  logic       ldh,
  input  logic       inc,
  input  logic       br,
  output logic [7:0] pcl,
  output logic [7:0] pch,
  output logic       busy,
  output logic       pgx
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FIX  = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_nx_s;
  logic [7:0]  pcl_r;
  logic [7:0]  pch_r;
  logic [7:0]  pcl_nx_s;
  logic [7:0]  pch_nx_s;
  logic        dir_r;
  logic        dir_nx_s;
  logic        busy_r;
  logic        pgx_r;
  logic [8:0]  sum9_s;
  logic [15:0] pc_inc_s;
  logic        cross_s;

  // Step a byte by one, up when dn is 0 and down when dn is 1 (mod 256).
  function automatic logic [7:0] byte_step(input logic [7:0] b, input logic dn);
    logic [7:0] r;
    if (dn) begin
      r = b - 8'd1;
    end else begin
      r = b + 8'd1;
    end
    return r;
  endfunction

  // Datapath arithmetic shared by the next-state logic.
  always_comb begin
    sum9_s   = {1'b0, pcl_r} + {1'b0, din};
    pc_inc_s = {pch_r, pcl_r} + 16'd1;
    // A carry out on a positive offset or no carry on a negative offset
    // means the target lies in the neighbouring page.
    cross_s  = (din[7] != sum9_s[8]);
  end

  // Next-state and next-PC selection; IDLE priority is loads, then branch, then inc.
  always_comb begin
    state_nx_s = state_r;
    pcl_nx_s   = pcl_r;
    pch_nx_s   = pch_r;
    dir_nx_s   = dir_r;
    case (state_r)
      ST_IDLE: begin
        if (ldl || ldh) begin
          if (ldl) begin
            pcl_nx_s = din;
          end else begin
            pcl_nx_s = pcl_r;
          end
          if (ldh) begin
            pch_nx_s = din;
          end else begin
            pch_nx_s = pch_r;
          end
        end else if (br) begin
          pcl_nx_s = sum9_s[7:0];
          if (cross_s) begin
            state_nx_s = ST_FIX;
            dir_nx_s   = din[7];
          end else begin
            state_nx_s = ST_IDLE;
          end
        end else if (inc) begin
          pch_nx_s = pc_inc_s[15:8];
          pcl_nx_s = pc_inc_s[7:0];
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_FIX: begin
        // Commands are ignored here; only the high-byte fixup happens.
        pch_nx_s   = byte_step(pch_r, dir_r);
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, PC and flag registers; reset restores the vector-fetch address
  // and discards any pending fixup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      pcl_r   <= RST_PC[7:0];
      pch_r   <= RST_PC[15:8];
      dir_r   <= 1'b0;
      busy_r  <= 1'b0;
      pgx_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      pcl_r   <= pcl_nx_s;
      pch_r   <= pch_nx_s;
      dir_r   <= dir_nx_s;
      // busy/pgx are flops that mirror "next state is FIX", so they are
      // high exactly while the state register holds FIX.
      busy_r  <= (state_nx_s == ST_FIX);
      pgx_r   <= (state_nx_s == ST_FIX);
    end
  end

  assign pcl  = pcl_r;
  assign pch  = pch_r;
  assign busy = busy_r;
  assign pgx  = pgx_r;

endmodule

// File: tb/tb_pc16_unit.sv
// Self-checking bench for pc16_unit: directed reset sequences, a vector
// table of single commands, and randomized traffic against a PC model.
module tb_pc16_unit;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       ldl;
  logic       ldh;
  logic       inc;
  logic       br;
  logic [7:0] pcl;
  logic [7:0] pch;
  logic       busy;
  logic       pgx;

  int checks;
  int errors;

  pc16_unit #(.RST_PC(16'hFFFC)) dut (
    .clk (clk),
    .rst (rst),
    .din (din),
    .ldl (ldl),
    .ldh (ldh),
    .inc (inc),
    .br  (br),
    .pcl (pcl),
    .pch (pch),
    .busy(busy),
    .pgx (pgx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] start;
    logic        ldl;
    logic        ldh;
    logic        inc;
    logic        br;
    logic [7:0]  din;
    logic [15:0] exp1;
    logic        exp_fix;
    logic [15:0] exp2;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ldl = 1'b0; ldh = 1'b0; inc = 1'b0; br = 1'b0; din = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pc(input logic [15:0] v);
    idle_inputs();
    ldl = 1'b1; din = v[7:0];
    tick();
    ldl = 1'b0; ldh = 1'b1; din = v[15:8];
    tick();
    idle_inputs();
  endtask

  // Reference model: PC as a 16-bit number, branch target computed as a
  // whole-word signed add; a target on another page needs a second cycle.
  logic [15:0] m_pc;
  logic        m_fix;
  logic [15:0] m_target;

  task automatic model_step();
    logic [15:0] tgt;
    if (m_fix) begin
      m_pc  = m_target;
      m_fix = 1'b0;
    end else if (ldl || ldh) begin
      if (ldl) m_pc[7:0]  = din;
      if (ldh) m_pc[15:8] = din;
    end else if (br) begin
      tgt = m_pc + {{8{din[7]}}, din};
      if (tgt[15:8] == m_pc[15:8]) begin
        m_pc = tgt;
      end else begin
        m_pc     = {m_pc[15:8], tgt[7:0]};
        m_target = tgt;
        m_fix    = 1'b1;
      end
    end else if (inc) begin
      m_pc = m_pc + 16'd1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    idle_inputs();

    vecs[0]  = '{16'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 16'h1200, 1'b0, 16'h1200};
    vecs[1]  = '{16'h1010, 1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 16'h1030, 1'b0, 16'h1030};
    vecs[2]  = '{16'h10F0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 16'h1010, 1'b1, 16'h1110};
    vecs[3]  = '{16'h1005, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, 16'h10F5, 1'b1, 16'h0FF5};
    vecs[4]  = '{16'h0005, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, 16'h00F5, 1'b1, 16'hFFF5};
    vecs[5]  = '{16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h1234, 1'b0, 16'h1234};
    vecs[6]  = '{16'h1280, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 16'h1200, 1'b0, 16'h1200};
    vecs[7]  = '{16'h1200, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 16'h1280, 1'b1, 16'h1180};
    vecs[8]  = '{16'hFFF0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 16'hFF10, 1'b1, 16'h0010};
    vecs[9]  = '{16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 8'hAB, 16'hABAB, 1'b0, 16'hABAB};
    vecs[10] = '{16'h12FF, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 16'h1300, 1'b0, 16'h1300};
    vecs[11] = '{16'h1234, 1'b0, 1'b1, 1'b1, 1'b1, 8'h56, 16'h5634, 1'b0, 16'h5634};

    // Reset asserted between edges takes effect immediately.
    tick();
    #2 rst = 1'b1;
    #1;
    check("rst_pc", {pch, pcl}, 16'hFFFC);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_pgx", {15'd0, pgx}, 16'd0);
    rst = 1'b0;
    inc = 1'b1;
    tick(); check("inc1", {pch, pcl}, 16'hFFFD);
    tick(); check("inc2", {pch, pcl}, 16'hFFFE);
    tick(); check("inc3", {pch, pcl}, 16'hFFFF);
    tick(); check("inc_wrap", {pch, pcl}, 16'h0000);
    idle_inputs();

    // Separate byte loads.
    load_pc(16'h1234);
    check("load_pc", {pch, pcl}, 16'h1234);

    // Table of single commands; FIX cycles get inc and br held high.
    for (int i = 0; i < 12; i++) begin
      load_pc(vecs[i].start);
      ldl = vecs[i].ldl; ldh = vecs[i].ldh; inc = vecs[i].inc;
      br = vecs[i].br; din = vecs[i].din;
      tick();
      check($sformatf("vec%0d_edge1", i), {pch, pcl}, vecs[i].exp1);
      check($sformatf("vec%0d_busy1", i), {15'd0, busy}, {15'd0, vecs[i].exp_fix});
      check($sformatf("vec%0d_pgx1", i), {15'd0, pgx}, {15'd0, vecs[i].exp_fix});
      if (vecs[i].exp_fix) begin
        idle_inputs();
        inc = 1'b1; br = 1'b1; din = 8'h40;
        tick();
        check($sformatf("vec%0d_edge2", i), {pch, pcl}, vecs[i].exp2);
        check($sformatf("vec%0d_busy2", i), {15'd0, busy}, 16'd0);
        check($sformatf("vec%0d_pgx2", i), {15'd0, pgx}, 16'd0);
      end
      idle_inputs();
    end

    // Reset in the middle of a fixup abandons it.
    load_pc(16'h10F0);
    br = 1'b1; din = 8'h20;
    tick();
    check("midfix_pre", {pch, pcl}, 16'h1010);
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    check("midfix_rst_pc", {pch, pcl}, 16'hFFFC);
    check("midfix_rst_busy", {15'd0, busy}, 16'd0);
    rst = 1'b0;
    inc = 1'b1;
    tick();
    check("midfix_inc", {pch, pcl}, 16'hFFFD);
    idle_inputs();
    tick();
    check("midfix_stale", {pch, pcl}, 16'hFFFD);
    check("midfix_busy", {15'd0, busy}, 16'd0);

    // Randomized traffic against the model.
    load_pc(16'h10F0);
    m_pc = 16'h10F0;
    m_fix = 1'b0;
    m_target = 16'h0000;
    for (int n = 0; n < 400; n++) begin
      din = 8'($urandom_range(0, 255));
      ldl = ($urandom_range(0, 9) == 0);
      ldh = ($urandom_range(0, 9) == 0);
      br  = ($urandom_range(0, 2) == 0);
      inc = ($urandom_range(0, 1) == 0);
      model_step();
      tick();
      check($sformatf("rnd%0d_pc", n), {pch, pcl}, m_pc);
      check($sformatf("rnd%0d_busy", n), {15'd0, busy}, {15'd0, m_fix});
      check($sformatf("rnd%0d_pgx", n), {15'd0, pgx}, {15'd0, m_fix});
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
